// File: rtl/dco_freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// 2^GATE_LOG2-cycle window and rescales the count into the NCO tuning-word domain.
module dco_freq_meter #(
    parameter int WIDTH       = 32,
    parameter int GATE_LOG2   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 start,
    input  logic                 continuous,
    output logic                 busy,
    output logic                 meas_valid,
    output logic [GATE_LOG2-1:0] edge_count,
    output logic [WIDTH-1:0]     tuning_est
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [GATE_LOG2-1:0] GATE_LAST = {GATE_LOG2{1'b1}};
    localparam logic [GATE_LOG2-1:0] GATE_ZERO = {GATE_LOG2{1'b0}};
    localparam logic [GATE_LOG2-1:0] GATE_ONE  = {{(GATE_LOG2-1){1'b0}}, 1'b1};

    // A window of 2^GATE_LOG2 cycles means each count is worth 2^(WIDTH-GATE_LOG2) in tuning units.
    function automatic logic [WIDTH-1:0] scale_count(input logic [GATE_LOG2-1:0] cnt);
        logic [WIDTH-1:0] v;
        v                = {WIDTH{1'b0}};
        v[GATE_LOG2-1:0] = cnt;
        return v << (WIDTH - GATE_LOG2);
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [0:0]             r_state;
    logic [GATE_LOG2-1:0]   r_gate;
    logic [GATE_LOG2-1:0]   r_acc;
    logic                   r_busy;
    logic                   r_meas_valid;
    logic [GATE_LOG2-1:0]   r_edge_count;
    logic [WIDTH-1:0]       r_tuning_est;

    logic                   w_rise;
    logic                   w_gate_done;
    logic [GATE_LOG2-1:0]   w_acc_total;
    logic [0:0]             w_state_nxt;
    logic                   w_gate_load;

    assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_gate_done = (r_state == ST_MEASURE) && (r_gate == GATE_ZERO);
    assign w_acc_total = r_acc + {{(GATE_LOG2-1){1'b0}}, w_rise};

    // Synchronizer and edge-detect history run in every state.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Next-state decode; a window reload happens on start from IDLE or on a continuous rollover.
    always_comb begin
        w_state_nxt = r_state;
        w_gate_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_MEASURE;
                    w_gate_load = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (r_gate == GATE_ZERO) begin
                    if (continuous) begin
                        w_state_nxt = ST_MEASURE;
                        w_gate_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gate_load = 1'b0;
            end
        endcase
    end

    // Window state, gate counter and edge accumulator.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_gate  <= GATE_ZERO;
            r_acc   <= GATE_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_MEASURE);
            if (w_gate_load) begin
                r_gate <= GATE_LAST;
                r_acc  <= GATE_ZERO;
            end else if (r_state == ST_MEASURE) begin
                r_gate <= r_gate - GATE_ONE;
                r_acc  <= w_acc_total;
            end else begin
                r_gate <= r_gate;
                r_acc  <= r_acc;
            end
        end
    end

    // Result registers include the final-cycle rise and hold until the next window ends.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_meas_valid <= 1'b0;
            r_edge_count <= GATE_ZERO;
            r_tuning_est <= {WIDTH{1'b0}};
        end else begin
            r_meas_valid <= w_gate_done;
            if (w_gate_done) begin
                r_edge_count <= w_acc_total;
                r_tuning_est <= scale_count(w_acc_total);
            end else begin
                r_edge_count <= r_edge_count;
                r_tuning_est <= r_tuning_est;
            end
        end
    end

    assign busy       = r_busy;
    assign meas_valid = r_meas_valid;
    assign edge_count = r_edge_count;
    assign tuning_est = r_tuning_est;

endmodule

// File: tb/tb_dco_freq_meter.sv
// Self-checking bench for dco_freq_meter: window-level reference model compared
// every cycle, plus hand-computed expectations for the characteristic scenarios.
module tb_dco_freq_meter;

    localparam int WIN = 4096;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        busy;
    logic        meas_valid;
    logic [11:0] edge_count;
    logic [31:0] tuning_est;

    int n_checks = 0;
    int n_fail   = 0;

    dco_freq_meter #(.WIDTH(32), .GATE_LOG2(12), .SYNC_STAGES(2)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .start      (start),
        .continuous (continuous),
        .busy       (busy),
        .meas_valid (meas_valid),
        .edge_count (edge_count),
        .tuning_est (tuning_est)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", nm, got, got, exp, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input logic [63:0] got, input logic [63:0] lo, input logic [63:0] hi);
        n_checks++;
        if ($isunknown(got) || got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d at t=%0t", nm, got, lo, hi, $time);
        end
    endtask

    // Stimulus source for sig_in: square wave of half-period sig_half, constant, or random bits.
    int sig_half  = 1;
    int ph        = 0;
    bit sig_const = 1'b0;
    bit sig_rand  = 1'b0;
    initial forever begin
        @(posedge sys_clk);
        #2;
        if (sig_rand) sig_in = 1'($urandom_range(0, 1));
        else if (sig_half == 0) sig_in = sig_const;
        else begin
            ph++;
            if (ph >= sig_half) begin
                ph     = 0;
                sig_in = ~sig_in;
            end
        end
    end

    // Reference model. Cycle k is the interval after clock edge k. A rise is seen
    // inside the meter in cycle c when sig_in was high in cycle c-2 and low in c-3.
    bit hist [0:131071];
    int cyc      = 0;
    bit m_busy   = 1'b0;
    bit m_valid  = 1'b0;
    int m_left   = 0;
    int m_cnt    = 0;
    int m_res    = 0;
    bit model_ok = 1'b0;

    function automatic int rise_at(input int c);
        if (c < 3) return 0;
        return (hist[c-2] && !hist[c-3]) ? 1 : 0;
    endfunction

    always @(posedge sys_clk) begin
        cyc++;
        if (cyc > 100000) begin
            $display("FAIL watchdog: cycle budget exceeded, got %0d cycles, expected under 100000", cyc);
            $fatal(1);
        end
        hist[cyc-1] = sig_in;
        if (rst) begin
            for (int k = 1; k <= 3; k++) if (cyc - k >= 0) hist[cyc-k] = 1'b0;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_left  = 0;
            m_cnt   = 0;
            m_res   = 0;
        end else begin
            m_valid = 1'b0;
            if (m_busy) begin
                m_cnt  += rise_at(cyc - 1);
                m_left -= 1;
                if (m_left == 0) begin
                    m_res   = m_cnt;
                    m_valid = 1'b1;
                    m_cnt   = 0;
                    if (continuous) m_left = WIN;
                    else m_busy = 1'b0;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = WIN;
                m_cnt  = 0;
            end
        end
        model_ok = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sys_clk) begin
        if (model_ok && n_fail < 200) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("meas_valid", 64'(meas_valid), 64'(m_valid));
            chk("edge_count", 64'(edge_count), 64'(m_res));
            chk("tuning_est", 64'(tuning_est), 64'(m_res) << 20);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        while (!ok && edges < max) begin
            tick(1);
            edges++;
            ok = meas_valid;
        end
    endtask

    int e;
    int e2;
    bit ok;

    initial begin
        // Reset with sig_in toggling and start held high.
        sig_half = 1;
        start    = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            chk("reset busy", 64'(busy), 64'd0);
            chk("reset meas_valid", 64'(meas_valid), 64'd0);
            chk("reset edge_count", 64'(edge_count), 64'd0);
            chk("reset tuning_est", 64'(tuning_est), 64'd0);
            tick(1);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick(3);
        chk("idle busy", 64'(busy), 64'd0);

        // Nominal ~1 MHz case: period 100 cycles.
        sig_half = 50;
        tick($urandom_range(200, 299));
        do_start();
        wait_valid(WIN + 100, e, ok);
        chk("nominal timeout", 64'(ok), 64'd1);
        chk("nominal latency", 64'(e), 64'd4096);
        chk_rng("nominal edge_count", 64'(edge_count), 64'd40, 64'd41);
        chk_rng("nominal tuning_est", 64'(tuning_est), 64'd41943040, 64'd42991616);
        chk("nominal busy at result", 64'(busy), 64'd0);

        // Maximum rate: toggle every cycle.
        sig_half = 1;
        tick(20);
        do_start();
        wait_valid(WIN + 100, e, ok);
        chk("maxrate timeout", 64'(ok), 64'd1);
        chk("maxrate edge_count", 64'(edge_count), 64'd2048);
        chk("maxrate tuning_est", 64'(tuning_est), 64'h8000_0000);
        chk("maxrate model", 64'(m_res), 64'd2048);

        // Constant high, then constant low.
        for (int lvl = 1; lvl >= 0; lvl--) begin
            sig_half  = 0;
            sig_const = 1'(lvl);
            tick(10);
            do_start();
            wait_valid(WIN + 100, e, ok);
            chk("const timeout", 64'(ok), 64'd1);
            chk("const edge_count", 64'(edge_count), 64'd0);
            chk("const tuning_est", 64'(tuning_est), 64'd0);
        end

        // Continuous mode with period 50.
        sig_half   = 25;
        ph         = 0;
        tick(300);
        continuous = 1'b1;
        do_start();
        for (int w = 0; w < 2; w++) begin
            wait_valid(WIN + 100, e, ok);
            chk("cont timeout", 64'(ok), 64'd1);
            chk("cont interval", 64'(e), 64'd4096);
            chk("cont busy held", 64'(busy), 64'd1);
            chk_rng("cont edge_count", 64'(edge_count), 64'd81, 64'd82);
        end
        tick(2000);
        continuous = 1'b0;
        wait_valid(WIN + 100, e, ok);
        chk("cont last timeout", 64'(ok), 64'd1);
        chk("cont last interval", 64'(e), 64'd2096);
        chk("cont last busy", 64'(busy), 64'd0);
        chk_rng("cont last edge_count", 64'(edge_count), 64'd81, 64'd82);
        tick(10);
        chk("cont stopped", 64'(busy), 64'd0);

        // start while busy is ignored.
        sig_half = 50;
        do_start();
        tick(100);
        do_start();
        wait_valid(WIN + 100, e, ok);
        chk("busy-start timeout", 64'(ok), 64'd1);
        chk("busy-start latency", 64'(101 + e), 64'd4096);
        tick(5);
        chk("busy-start no queue", 64'(busy), 64'd0);

        // Abort by reset 1000 cycles into a window.
        do_start();
        tick(1000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort meas_valid", 64'(meas_valid), 64'd0);
        chk("abort edge_count", 64'(edge_count), 64'd0);
        chk("abort tuning_est", 64'(tuning_est), 64'd0);
        wait_valid(3200, e, ok);
        chk("abort no result", 64'(ok), 64'd0);

        // Fresh measurement after the abort.
        do_start();
        wait_valid(WIN + 100, e, ok);
        chk("fresh timeout", 64'(ok), 64'd1);
        chk_rng("fresh edge_count", 64'(edge_count), 64'd40, 64'd41);

        // Single rise landing in the last window cycle is counted; one cycle later it is not.
        for (int late = 0; late < 2; late++) begin
            sig_half  = 0;
            sig_const = 1'b0;
            tick(10);
            do_start();
            tick(4093 + late);
            sig_const = 1'b1;
            wait_valid(WIN + 100, e2, ok);
            chk("final-cycle timeout", 64'(ok), 64'd1);
            chk("final-cycle edge_count", 64'(edge_count), 64'(late == 0 ? 1 : 0));
            chk("final-cycle model", 64'(m_res), 64'(late == 0 ? 1 : 0));
        end

        // Randomized single-shot measurements.
        for (int r = 0; r < 3; r++) begin
            sig_rand = ($urandom_range(0, 3) == 0);
            sig_half = $urandom_range(1, 80);
            tick($urandom_range(5, 60));
            do_start();
            wait_valid(WIN + 100, e, ok);
            chk("random timeout", 64'(ok), 64'd1);
            chk("random latency", 64'(e), 64'd4096);
        end
        sig_rand = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dco_freq_meter.md
# dco_freq_meter

Gated frequency meter that measures a square wave produced by the DCO/NCO and reports it back as an equivalent tuning word. It counts rising edges of `sig_in` over a fixed window of 2^GATE_LOG2 `sys_clk` cycles and scales the count into the NCO tuning-word domain. This closes the loop between the tuning word that drives the DCO and the frequency the DCO actually produces, for PLL bring-up and self-check.

## Interface

- `WIDTH`, 32: tuning-word width; must match the DCO accumulator width.
- `GATE_LOG2`, 12: gate window is 2^GATE_LOG2 `sys_clk` cycles; legal range 2..WIDTH.
- `SYNC_STAGES`, 2: synchronizer depth on `sig_in`; minimum 2.

- `sys_clk`  in  1  single system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sig_in`  in  1  signal under measurement, e.g. DCO output; treated as asynchronous.
- `start`  in  1  request one measurement; sampled only in IDLE.
- `continuous`  in  1  when high at the end of a window, the next window starts with no gap.
- `busy`  out  1  high while a window is open.
- `meas_valid`  out  1  one-cycle pulse when a new result is presented.
- `edge_count`  out  GATE_LOG2  rising edges counted in the last completed window.
- `tuning_est`  out  WIDTH  `edge_count << (WIDTH - GATE_LOG2)`, zero-filled low bits.

## Operation

- Input path: `sig_in` passes through a SYNC_STAGES flop chain, then one `prev` flop. `rise = sync_out & ~prev`. The chain and `prev` run in all states, including IDLE.
- FSM states:
  - IDLE: `start` = 1 → MEASURE. The gate counter loads 2^GATE_LOG2 − 1 and the edge accumulator clears.
  - MEASURE: each cycle the accumulator adds `rise` and the gate counter decrements.
- Last MEASURE cycle (gate counter = 0):
  - The result registers load `acc + rise`, so an edge in the final cycle is counted.
  - `meas_valid` pulses in the next cycle.
  - If `continuous` = 1, stay in MEASURE: gate counter reloads and accumulator clears to 0 in the same edge.
  - Otherwise go to IDLE.
- `start` while busy is ignored, with no queueing.
- Deasserting `continuous` mid-window lets the current window finish and deliver its result, then the FSM returns to IDLE.
- Arithmetic:
  - A sampled signal yields at most 2^(GATE_LOG2−1) rises per window, so `edge_count` never overflows.
  - `tuning_est` maximum is 2^(WIDTH−1); no saturation logic is needed.
- `edge_count` and `tuning_est` hold their last result until the next one is written. They change only in the cycle `meas_valid` is high.
- Reset: in any state, `rst` forces IDLE and clears the synchronizer, `prev`, the gate counter, the accumulator and all outputs. An aborted window produces no `meas_valid`.

## Timing

- Reset values: `busy` = 0, `meas_valid` = 0, `edge_count` = 0, `tuning_est` = 0.
- `start` sampled high at edge t:
  - `busy` is high from cycle t+1 through t+2^GATE_LOG2 (MEASURE cycles).
  - `meas_valid` is high in cycle t+2^GATE_LOG2+1.
  - `busy` is low in that cycle unless `continuous` = 1.
- Continuous mode: `meas_valid` pulses exactly every 2^GATE_LOG2 cycles and `busy` stays high throughout.
- `sig_in` rising edge to `rise`: SYNC_STAGES+1 cycles. Edges within that latency of window end count in the next window, or are dropped if the FSM returns to IDLE.
- Single-shot throughput: a new `start` is accepted at the earliest in the cycle `meas_valid` is high. The new window begins the cycle after that.
- Quantization: ±1 edge per window, i.e. ±2^(WIDTH−GATE_LOG2) in `tuning_est`.

## Test plan

All scenarios use default parameters.

- Reset/idle: hold `rst` 5 cycles with `sig_in` toggling → all outputs 0; `start` under `rst` → `busy` stays 0.
- Nominal, ~1 MHz case: `sig_in` period 100 cycles (50 high/50 low), one `start` → `meas_valid` exactly 4097 cycles after the start edge; `edge_count` in 40..41; `tuning_est` in 41943040..42991616, bracketing 42949673.
- Max rate: `sig_in` toggling every cycle → `edge_count` = 2048, `tuning_est` = 0x8000_0000; any `sig_in` constant high or low → `edge_count` = 0, `tuning_est` = 0.
- Continuous: `continuous` = 1, `sig_in` period 50 → `meas_valid` every 4096 cycles, `busy` never drops, `edge_count` in 81..82. Clear `continuous` mid-window → exactly one more result, then `busy` = 0.
- Busy/abort:
  - Pulse `start` 100 cycles into a window → ignored; result timing unchanged.
  - Assert `rst` 1000 cycles into a window → `busy` = 0 next cycle, outputs 0, no `meas_valid`.
  - A fresh `start` after the abort measures correctly.
- Final-cycle edge: align a single `sig_in` rise so `rise` asserts in the last MEASURE cycle → `edge_count` = 1.
